// File: rtl/fir_decim_pkg.sv
// Shared definitions for the FIR lowpass decimator datapath.
//   acc_size()    : accumulator/reduction width for a given sample, coefficient
//                   and term-count configuration.
//   sat_to_width(): clamp a sign-extended value to a w-bit signed range.
//   state_t       : output-sequencer state encoding (IDLE/REDUCE/ROUND).
package fir_decim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REDUCE = 2'd1,
        ST_ROUND  = 2'd2
    } state_t;

    // Product width plus enough guard bits to sum every term of every lane.
    function automatic int acc_size(input int sample_w, input int coeff_w,
                                    input int mac_size, input int mac_num);
        return sample_w + coeff_w + $clog2(mac_size * mac_num);
    endfunction

    // Clamp v to [-2^(w-1), 2^(w-1)-1]; the caller truncates to w bits.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] v,
                                                        input int w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/mac_accumulator_if.sv
// Lane-data / result bus of the MAC accumulator.
//   master: drives s_in, c_in, mac_en, mac_first, mac_last; observes results.
//   slave : the accumulator; drives y_out, y_valid, busy, overrun.
interface mac_accumulator_if #(
    parameter int SAMPLE_SIZE = 16,
    parameter int COEFF_SIZE  = 16,
    parameter int MAC_NUM     = 1,
    parameter int OUT_SIZE    = 16
);
    logic [SAMPLE_SIZE*MAC_NUM-1:0] s_in;
    logic [COEFF_SIZE*MAC_NUM-1:0]  c_in;
    logic                           mac_en;
    logic                           mac_first;
    logic                           mac_last;
    logic signed [OUT_SIZE-1:0]     y_out;
    logic                           y_valid;
    logic                           busy;
    logic                           overrun;

    modport master (
        output s_in, c_in, mac_en, mac_first, mac_last,
        input  y_out, y_valid, busy, overrun
    );

    modport slave (
        input  s_in, c_in, mac_en, mac_first, mac_last,
        output y_out, y_valid, busy, overrun
    );
endinterface

// File: rtl/mac_lane.sv
// One multiply-accumulate lane.
//   clk, rst  : clock, synchronous active-high reset
//   en        : s/c carry a valid term this cycle
//   s, c      : signed sample / coefficient
//   en_p1     : en delayed to the product stage
//   first_p1  : first-term flag delayed to the product stage
//   acc_next  : accumulator value being written this cycle (used for snapshot)
module mac_lane #(
    parameter int SAMPLE_SIZE = 16,
    parameter int COEFF_SIZE  = 16,
    parameter int ACC_SIZE    = 40
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic signed [SAMPLE_SIZE-1:0] s,
    input  logic signed [COEFF_SIZE-1:0]  c,
    input  logic                          en_p1,
    input  logic                          first_p1,
    output logic signed [ACC_SIZE-1:0]    acc_next
);
    localparam int PROD_W = SAMPLE_SIZE + COEFF_SIZE;

    logic signed [PROD_W-1:0]   s_ext;
    logic signed [PROD_W-1:0]   c_ext;
    logic signed [PROD_W-1:0]   prod_p1;
    logic signed [ACC_SIZE-1:0] prod_ext;
    logic signed [ACC_SIZE-1:0] acc_p2;

    // Widen before multiplying so the full signed product is kept.
    assign s_ext    = s;
    assign c_ext    = c;
    assign prod_ext = prod_p1;
    assign acc_next = first_p1 ? prod_ext : acc_p2 + prod_ext;

    // ---- stage p1: product register ----
    always_ff @(posedge clk) begin
        if (rst)     prod_p1 <= '0;
        else if (en) prod_p1 <= s_ext * c_ext;
    end

    // ---- stage p2: accumulator ----
    always_ff @(posedge clk) begin
        if (rst)        acc_p2 <= '0;
        else if (en_p1) acc_p2 <= acc_next;
    end
endmodule

// File: rtl/mac_accumulator.sv
// Multi-lane MAC accumulator for the polyphase FIR decimator.
// Accumulates per-lane products, snapshots the lane totals when the last term
// lands, reduces the lanes one per cycle, rounds half up, saturates and emits
// one output sample with a single-cycle y_valid pulse.
//   clk, rst : clock, synchronous active-high reset
//   bus      : mac_accumulator_if.slave (lane inputs, result, busy, overrun)
module mac_accumulator
    import fir_decim_pkg::*;
#(
    parameter int MAC_SIZE    = 255,
    parameter int MAC_NUM     = 1,
    parameter int COEFF_SIZE  = 16,
    parameter int SAMPLE_SIZE = 16,
    parameter int OUT_SIZE    = 16,
    parameter int FRAC_SHIFT  = 15
) (
    input  logic             clk,
    input  logic             rst,
    mac_accumulator_if.slave bus
);
    localparam int ACC_SIZE = acc_size(SAMPLE_SIZE, COEFF_SIZE, MAC_SIZE, MAC_NUM);
    localparam int K_W      = (MAC_NUM > 1) ? $clog2(MAC_NUM) : 1;
    localparam logic [K_W-1:0] K_LAST = K_W'(MAC_NUM - 1);
    localparam int RND_SH   = (FRAC_SHIFT > 0) ? FRAC_SHIFT - 1 : 0;
    localparam logic signed [ACC_SIZE-1:0] RND_BIAS =
        (FRAC_SHIFT > 0) ? (ACC_SIZE'(1) <<< RND_SH) : '0;

    // Round half toward +inf, then drop the fractional bits.
    function automatic logic signed [ACC_SIZE-1:0] round_shift(
        input logic signed [ACC_SIZE-1:0] v);
        logic signed [ACC_SIZE-1:0] t;
        t = v + RND_BIAS;
        return t >>> FRAC_SHIFT;
    endfunction

    state_t state_q;
    state_t state_d;

    logic                       vld_p1;
    logic                       first_p1;
    logic                       last_p1;
    logic                       last_done;
    logic                       snap_en;
    logic                       red_en;
    logic                       out_en;
    logic [K_W-1:0]             k_q;
    logic signed [ACC_SIZE-1:0] acc_next [MAC_NUM];
    logic signed [ACC_SIZE-1:0] snap     [MAC_NUM];
    logic signed [ACC_SIZE-1:0] sum_q;
    logic signed [ACC_SIZE-1:0] rnd;
    logic signed [63:0]         rnd64;
    logic signed [63:0]         sat64;
    logic signed [OUT_SIZE-1:0] y_out_q;
    logic                       y_valid_q;
    logic                       busy_q;
    logic                       overrun_q;

    // ---- stage p1/p2: per-lane product and accumulator ----
    for (genvar j = 0; j < MAC_NUM; j++) begin : g_lane
        mac_lane #(
            .SAMPLE_SIZE(SAMPLE_SIZE),
            .COEFF_SIZE (COEFF_SIZE),
            .ACC_SIZE   (ACC_SIZE)
        ) u_lane (
            .clk     (clk),
            .rst     (rst),
            .en      (bus.mac_en),
            .s       (bus.s_in[j*SAMPLE_SIZE +: SAMPLE_SIZE]),
            .c       (bus.c_in[j*COEFF_SIZE +: COEFF_SIZE]),
            .en_p1   (vld_p1),
            .first_p1(first_p1),
            .acc_next(acc_next[j])
        );
    end

    // The last term is being folded into the accumulators this cycle.
    assign last_done = vld_p1 & last_p1;

    assign rnd   = round_shift(sum_q);
    assign rnd64 = {{(64-ACC_SIZE){rnd[ACC_SIZE-1]}}, rnd};
    assign sat64 = sat_to_width(rnd64, OUT_SIZE);

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        snap_en = 1'b0;
        red_en  = 1'b0;
        out_en  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (last_done) begin
                    snap_en = 1'b1;
                    state_d = ST_REDUCE;
                end
            end
            ST_REDUCE: begin
                red_en = 1'b1;
                if (k_q == K_LAST) state_d = ST_ROUND;
            end
            ST_ROUND: begin
                out_en  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ---- stage p1 control flags, sequencer control and outputs ----
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1    <= 1'b0;
            first_p1  <= 1'b0;
            last_p1   <= 1'b0;
            k_q       <= '0;
            busy_q    <= 1'b0;
            y_valid_q <= 1'b0;
            y_out_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            vld_p1    <= bus.mac_en;
            first_p1  <= bus.mac_en & bus.mac_first;
            last_p1   <= bus.mac_en & bus.mac_last;
            y_valid_q <= out_en;
            if (snap_en)
                k_q <= '0;
            else if (red_en && k_q != K_LAST)
                k_q <= k_q + K_W'(1);
            if (snap_en)     busy_q <= 1'b1;
            else if (out_en) busy_q <= 1'b0;
            if (out_en) y_out_q <= sat64[OUT_SIZE-1:0];
            // A completed output arriving while the previous one is still
            // being reduced is dropped; the reduction in flight is untouched.
            if (last_done && state_q != ST_IDLE) overrun_q <= 1'b1;
        end
    end

    // ---- reduction datapath: snapshot decouples the accumulators ----
    always_ff @(posedge clk) begin
        if (snap_en) begin
            for (int j = 0; j < MAC_NUM; j++) snap[j] <= acc_next[j];
            sum_q <= '0;
        end else if (red_en) begin
            sum_q <= sum_q + snap[k_q];
        end
    end

    assign bus.y_out   = y_out_q;
    assign bus.y_valid = y_valid_q;
    assign bus.busy    = busy_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_mac_accumulator.sv
// Scoreboard bench for mac_accumulator: one single-lane and one two-lane
// instance, expected outputs queued at stimulus time and checked on y_valid.
module tb_mac_accumulator;
    typedef struct {
        longint val;
        longint cyc;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    longint cyc = 0;
    int     checks = 0;
    int     errors = 0;
    longint sum1 = 0;
    longint sum2 = 0;
    exp_t   q1[$];
    exp_t   q2[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mac_accumulator_if #(.SAMPLE_SIZE(16), .COEFF_SIZE(16), .MAC_NUM(1), .OUT_SIZE(16)) if1 ();
    mac_accumulator_if #(.SAMPLE_SIZE(16), .COEFF_SIZE(16), .MAC_NUM(2), .OUT_SIZE(16)) if2 ();

    mac_accumulator #(.MAC_SIZE(4), .MAC_NUM(1)) dut1 (.clk(clk), .rst(rst), .bus(if1));
    mac_accumulator #(.MAC_SIZE(4), .MAC_NUM(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));

    task automatic check(input string tag, input longint obs, input longint exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Round half up by 2^15, clamp to 16-bit signed.
    function automatic longint model(input longint a);
        longint r;
        r = (a + 64'sd16384) >>> 15;
        if (r > 32767)  r = 32767;
        if (r < -32768) r = -32768;
        return r;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (if1.y_valid === 1'b1) begin
            if (q1.size() == 0) check("y1_unexpected", 1, 0);
            else begin
                e = q1.pop_front();
                check("y1_value", if1.y_out, e.val);
                check("y1_latency", cyc, e.cyc);
            end
        end
        if (if2.y_valid === 1'b1) begin
            if (q2.size() == 0) check("y2_unexpected", 1, 0);
            else begin
                e = q2.pop_front();
                check("y2_value", if2.y_out, e.val);
                check("y2_latency", cyc, e.cyc);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            if1.mac_en = 0; if1.mac_first = 0; if1.mac_last = 0;
            if2.mac_en = 0; if2.mac_first = 0; if2.mac_last = 0;
        end
    endtask

    task automatic term(input int sel, input int s0, input int s1, input int c,
                        input bit first, input bit last, input bit push);
        longint p;
        exp_t   e;
        @(posedge clk); #1;
        if (sel == 1) begin
            if1.s_in = 16'(s0); if1.c_in = 16'(c);
            if1.mac_en = 1; if1.mac_first = first; if1.mac_last = last;
            if2.mac_en = 0; if2.mac_first = 0; if2.mac_last = 0;
            p = longint'(s0) * longint'(c);
            if (first) sum1 = p; else sum1 += p;
            if (last && push) begin
                e.val = model(sum1); e.cyc = cyc + 4;
                q1.push_back(e);
            end
        end else begin
            if2.s_in = {16'(s1), 16'(s0)}; if2.c_in = {16'(c), 16'(c)};
            if2.mac_en = 1; if2.mac_first = first; if2.mac_last = last;
            if1.mac_en = 0; if1.mac_first = 0; if1.mac_last = 0;
            p = longint'(s0) * longint'(c) + longint'(s1) * longint'(c);
            if (first) sum2 = p; else sum2 += p;
            if (last && push) begin
                e.val = model(sum2); e.cyc = cyc + 5;
                q2.push_back(e);
            end
        end
    endtask

    task automatic send_block(input int sel, input int n, input int base, input int step,
                              input int s1, input int c, input bit push);
        for (int i = 0; i < n; i++)
            term(sel, base + i * step, s1, c, i == 0, i == n - 1, push);
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && (q1.size() != 0 || q2.size() != 0); i++)
            @(posedge clk);
        check(tag, q1.size() + q2.size(), 0);
    endtask

    initial begin
        if1.s_in = '0; if1.c_in = '0; if1.mac_en = 0; if1.mac_first = 0; if1.mac_last = 0;
        if2.s_in = '0; if2.c_in = '0; if2.mac_en = 0; if2.mac_first = 0; if2.mac_last = 0;
        rst = 1;
        idle(3);
        check("rst_y1", if1.y_out, 0);
        check("rst_v1", if1.y_valid, 0);
        check("rst_busy1", if1.busy, 0);
        check("rst_ovr1", if1.overrun, 0);
        check("rst_y2", if2.y_out, 0);
        check("rst_v2", if2.y_valid, 0);
        check("rst_busy2", if2.busy, 0);
        check("rst_ovr2", if2.overrun, 0);
        rst = 0;
        idle(2);

        send_block(1, 4, 100, 100, 0, 16'h4000, 1);       // -> 500
        idle(8);
        send_block(1, 4, 32767, 0, 0, 32767, 1);          // -> +sat
        idle(8);
        send_block(1, 4, -32768, 0, 0, 32767, 1);         // -> -sat
        idle(8);
        term(1, 1, 0, 16'h4000, 1, 1, 1);                 // -> 1
        idle(8);
        term(1, -1, 0, 16'h4000, 1, 1, 1);                // -> 0
        idle(8);
        send_block(1, 4, 10, 10, 0, 16'h4000, 1);         // back-to-back
        send_block(1, 4, -100, 0, 0, 16'h4000, 1);
        send_block(1, 3, 300, -7, 0, -8192, 1);
        idle(10);
        check("b2b_overrun1", if1.overrun, 0);
        drain("drain_dut1");

        send_block(2, 4, 100, 0, 50, 16'h4000, 1);        // lanes -> 300
        idle(10);
        check("lane_overrun2", if2.overrun, 0);
        send_block(2, 4, 200, 0, -100, 16'h4000, 1);      // kept
        idle(1);
        term(2, 7, 7, 16'h4000, 1, 1, 0);                 // dropped
        idle(12);
        check("overrun2_set", if2.overrun, 1);
        drain("drain_dut2");

        send_block(1, 4, 1000, 0, 0, 16'h4000, 0);
        idle(2);
        check("busy_in_reduce", if1.busy, 1);
        rst = 1;
        idle(1);
        rst = 0;
        check("mid_rst_y1", if1.y_out, 0);
        check("mid_rst_v1", if1.y_valid, 0);
        check("mid_rst_busy1", if1.busy, 0);
        check("mid_rst_ovr2", if2.overrun, 0);
        idle(10);
        check("post_rst_y1", if1.y_out, 0);
        check("post_rst_busy1", if1.busy, 0);
        drain("drain_end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
